freq_meter: RTL

// - Gated frequency counter: counts rising edges of an asynchronous input over a fixed gate window of

---
 rtl/freq_meter_pkg.sv | 22 ++
 rtl/freq_meter_sig_sync_edge.sv | 46 ++++
 rtl/freq_meter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_pkg
//
// Shared definitions for the gated frequency meter:
//   - state_e : two-state measurement FSM encoding
//   - DEFAULT_* constants used as parameter defaults by freq_meter and
//     sig_sync_edge (1 s gate at 48 MHz, 26-bit count, 2-flop synchronizer)
// ---------------------------------------------------------------------------
package freq_meter_pkg;

    // IDLE    : counters parked at zero, waiting for en
    // MEASURE : gate window running, edges being accumulated
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    localparam int DEFAULT_GATE_CYCLES = 48_000_000;
    localparam int DEFAULT_CNT_W       = 26;
    localparam int DEFAULT_SYNC_STAGES = 2;

endpackage : freq_meter_pkg

// File: rtl/freq_meter_sig_sync_edge.sv
// ---------------------------------------------------------------------------
// sig_sync_edge
//
// Brings an asynchronous level into the clk domain through a chain of
// SYNC_STAGES flops, then compares the synchronized level against one more
// delayed copy to produce a single-cycle pulse on each rising edge.
//
// Ports:
//   clk     in  1  system clock, rising edge
//   rst     in  1  synchronous active-high reset, clears the whole chain
//   sig_i   in  1  asynchronous input level
//   rise_o  out 1  one-cycle pulse per synchronized rising edge
// ---------------------------------------------------------------------------
module sig_sync_edge
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus the extra history flop used for edge detection.
    // Bit 0 is the metastability-exposed flop; only the last bit is used
    // by any logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A rising edge is "high now, low one cycle ago" on the synchronized level.
    // Since a 0 must be seen between two 1s, consecutive pulses are at least
    // two clocks apart, which caps the measurable rate at clk/2.
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : sig_sync_edge

// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
//
// Gated frequency counter. While enabled, counts rising edges of sig_in over
// back-to-back windows of GATE_CYCLES clocks and publishes each window's count
// through a valid/ready result register. Counts saturate at 2^CNT_W-1 and the
// saturation is reported alongside the count.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   rst         in   1      synchronous active-high reset
//   en          in   1      1 = measure continuously, 0 = idle
//   sig_in      in   1      asynchronous signal being measured
//   freq        out  CNT_W  edge count of the last completed window
//   overflow    out  1      freq is saturated
//   freq_valid  out  1      freq/overflow hold an unconsumed result
//   freq_ready  in   1      consumer accepts when freq_valid && freq_ready
//   overrun     out  1      sticky: an unconsumed result was overwritten
// ---------------------------------------------------------------------------
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             overflow,
    output logic             freq_valid,
    input  logic             freq_ready,
    output logic             overrun
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
    logic rise;

    sig_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .sig_i (sig_in),
        .rise_o(rise)
    );

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    state_e             state_q, state_d;
    logic               counting;
    logic               windowEnd;

    logic [GATE_W-1:0]  gateCnt_q, gateCnt_d;
    logic [CNT_W-1:0]   edgeCnt_q, edgeCnt_d;
    logic               satSeen_q, satSeen_d;

    logic [CNT_W:0]     edgeSum;
    logic               sumOvf;
    logic [CNT_W-1:0]   edgeSat;
    logic               resultOvf;

    logic [CNT_W-1:0]   freq_q, freq_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;
    logic               handshake;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic. Dropping en always returns to IDLE on the next
    // cycle; if that happens on the last cycle of a window the result is still
    // published by the datapath below because windowEnd does not look at en.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en)  state_d = MEASURE;
            MEASURE: if (!en) state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM outputs: whether we are inside a window and whether this cycle is
    // the last one of it.
    // -----------------------------------------------------------------------
    always_comb begin
        counting  = (state_q == MEASURE);
        windowEnd = counting && (gateCnt_q == GATE_LAST);
    end

    // -----------------------------------------------------------------------
    // Saturating accumulate of this cycle's edge. The extra MSB on edgeSum is
    // the carry that tells us the counter would have wrapped. satSeen_q
    // remembers an earlier saturation in the window so that the flag survives
    // even if no further edges arrive before the window closes.
    // -----------------------------------------------------------------------
    always_comb begin
        edgeSum   = {1'b0, edgeCnt_q} + (CNT_W + 1)'(rise);
        sumOvf    = edgeSum[CNT_W];
        edgeSat   = sumOvf ? CNT_MAX : edgeSum[CNT_W-1:0];
        resultOvf = satSeen_q | sumOvf;
    end

    // -----------------------------------------------------------------------
    // Gate and edge counter next state. Counters only advance while a window
    // is running and will keep running next cycle; at the window end, on a
    // disable, and in IDLE they return to zero so a new window always starts
    // clean and a partial window is simply dropped.
    // -----------------------------------------------------------------------
    always_comb begin
        gateCnt_d = '0;
        edgeCnt_d = '0;
        satSeen_d = 1'b0;
        if (counting && !windowEnd && en) begin
            gateCnt_d = gateCnt_q + GATE_W'(1);
            edgeCnt_d = edgeSat;
            satSeen_d = resultOvf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gateCnt_q <= '0;
            edgeCnt_q <= '0;
            satSeen_q <= 1'b0;
        end else begin
            gateCnt_q <= gateCnt_d;
            edgeCnt_q <= edgeCnt_d;
            satSeen_q <= satSeen_d;
        end
    end

    // -----------------------------------------------------------------------
    // Result register with valid/ready handshake. A handshake clears valid
    // and overrun; a new result then takes priority and re-asserts valid.
    // overrun is only raised when the result being replaced was still
    // unconsumed, so a result landing on the handshake cycle leaves it clear.
    // freq/overflow are held after consumption.
    // -----------------------------------------------------------------------
    always_comb begin
        handshake  = valid_q && freq_ready;
        freq_d     = freq_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        if (handshake) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (windowEnd) begin
            freq_d     = edgeSat;
            overflow_d = resultOvf;
            valid_d    = 1'b1;
            overrun_d  = valid_q && !freq_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freq_q     <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            freq_q     <= freq_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign freq       = freq_q;
    assign overflow   = overflow_q;
    assign freq_valid = valid_q;
    assign overrun    = overrun_q;

endmodule : freq_meter
